sha256_pad: RTL and testbench
=============================

# sha256_pad

Message-padding front end for the SHA-256 core. It accepts an arbitrary-length byte message as a 32-bit AXI-Stream, appends the FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and emits 512-bit blocks. Its output connects directly to the `axis_s_*` block input of `sha256_blk`, with `tlast` marking the final block of each message.

## Interface
Parameters:
- `LEN_W`, 61, width of the internal byte counter. The bit length is `{byte_cnt, 3'b000}`, zero-extended to 64 bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `arst_n`  in  1  asynchronous, active-low reset.
- `axis_s_tdata`  in  32  message word, big-endian: first byte in `[31:24]`.
- `axis_s_tkeep`  in  4  byte enables.
  - Non-last beats: must be `4'b1111`.
  - Last beat: one of `1111`, `1110`, `1100`, `1000`, `0000` (`0000` means no data bytes).
- `axis_s_tvalid`  in  1  input word valid.
- `axis_s_tlast`  in  1  last word of the message.
- `axis_s_t_ready`  out  1  input accepted when high with `tvalid`.
- `axis_m_tdata`  out  512  block; word 0 in `[511:480]`.
- `axis_m_tvalid`  out  1  block valid.
- `axis_m_tlast`  out  1  final block of the message.
- `axis_m_t_ready`  in  1  downstream accepts the block.

## Operation
- States:
  - `COLLECT`: accepting words.
  - `EMIT`: holding a block that is not final and no padding is pending.
  - `EMIT_P1`: first padded block.
  - `EMIT_P2`: extra final block.
- `axis_s_t_ready` = (state == `COLLECT`). The bench drives `axis_s_tvalid` low during reset.
- `COLLECT` with a non-last beat:
  - Store the word at index `w_idx` and add 4 to `byte_cnt`.
  - If `w_idx` == 15: go to `EMIT` (`tlast` = 0) and wrap `w_idx` to 0.
- `COLLECT` with a last beat at index `i`, with `n` = popcount(`tkeep`):
  - Store the valid bytes and add `n` to `byte_cnt`.
  - Marker placement:
    - If `n` < 4: write 0x80 at byte `n` of word `i`. Set `mark_w` = `i`.
    - If `n` == 4: put 0x80 at word `i`+1 (`mark_w` = `i`+1). If `i` == 15, the marker goes to word 0 of the next block: set `mark_pend`.
  - Zero all words after the marker within the block.
  - If `mark_w` ≤ 13 and `mark_pend` is clear: write the length into words 14–15 and go to `EMIT_P1` with `tlast` = 1.
  - Otherwise: go to `EMIT_P1` with `tlast` = 0, then `EMIT_P2`.
- `EMIT_P2` block:
  - All zeros, plus 0x80000000 in word 0 if `mark_pend` is set.
  - Length in words 14–15, `tlast` = 1.
- From any emit state: when `axis_m_t_ready` is high, the block is taken and the FSM advances.
  - After `EMIT`: return to `COLLECT`.
  - After `EMIT_P1` with `tlast` = 1: return to `COLLECT`.
  - After `EMIT_P1` with `tlast` = 0: go to `EMIT_P2`.
  - After `EMIT_P2`: return to `COLLECT`.
  - On returning to `COLLECT` after a final block: clear `byte_cnt`, `w_idx` and `mark_pend`.
- The block register is cleared to zero on entry to `COLLECT` after a final block.
- `byte_cnt` wraps modulo 2^`LEN_W`. Longer messages are out of scope.

## Timing
- Reset values:
  - `axis_m_tvalid` = 0, `axis_m_tlast` = 0, `axis_m_tdata` = 0.
  - `axis_s_t_ready` = 1 (state `COLLECT`).
  - `byte_cnt`, `w_idx` and `mark_pend` = 0.
- Latency: `axis_m_tvalid` rises the cycle after the accepting edge of the 16th word or the last word.
- Output stability: while `axis_m_tvalid` is high and `axis_m_t_ready` is low, `tdata` and `tlast` hold stable. `tvalid` never drops without a handshake.
- Back-to-back blocks: the `EMIT_P1` → `EMIT_P2` transition presents the new block in the cycle after the handshake edge. There is no bubble beyond the register.
- Input stall: `axis_s_t_ready` is 0 in every emit state. No input is accepted in the cycle the FSM leaves an emit state.
- Throughput: 16 input cycles + at least 1 emit cycle per full block.
- Reset mid-message: asynchronous return to reset values. The partial message and any held block are discarded, with no output handshake.

## Structure
- `sha256_pkg` holds:
  - `BLK_W` = 512, `WORD_W` = 32, `DIGEST_W` = 256.
  - The pad FSM state enum.
  - A function that inserts the 0x80 marker into a word given a keep count.
- There is no sub-module. A single `always_ff` holds the FSM, block register and counters, plus a combinational next-block build.

## Test plan
- Message "abc": one beat 0x61626300 with `tkeep` = 1110 and `tlast`. Expect one block 0x61626380_0…0_00000018 with `tlast` = 1. Fed into `sha256_blk`, the digest must be ba7816bf….
- Empty message: one beat with `tkeep` = 0000 and `tlast`. Expect a block with word 0 = 0x80000000, all other words 0, length 0, `tlast` = 1.
- 55 bytes (last beat at `i` = 13, `tkeep` = 1110):
  - Expect a single block.
  - Byte 55 = 0x80.
  - Words 14–15 = 0x00000000_000001B8.
  - `tlast` = 1.
- 56 bytes (`i` = 13, `tkeep` = 1111):
  - First block has word 14 = 0x80000000, word 15 = 0, `tlast` = 0.
  - Second block is all zeros except length 0x1C0, `tlast` = 1.
- 64 bytes:
  - First block is data only, `tlast` = 0.
  - Second block has word 0 = 0x80000000 and length 0x200, `tlast` = 1.
- Backpressure and reset:
  - Hold `axis_m_t_ready` low for 5 cycles during the 56-byte case. `tdata` and `tlast` must stay stable and `axis_s_t_ready` must stay 0.
  - Assert `arst_n` low mid-message. Afterwards `axis_m_tvalid` = 0, and the next "abc" message must pad correctly.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 widths, pad FSM state encoding and word-level padding helpers.
// Latency: n/a (package, no logic of its own).
// Backpressure: n/a.
package sha256_pkg;

    localparam int BLK_W    = 512;
    localparam int WORD_W   = 32;
    localparam int DIGEST_W = 256;

    localparam logic [WORD_W-1:0] MARK_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        EMIT_P1 = 2'd2,
        EMIT_P2 = 2'd3
    } pad_state_e;

    // Number of data bytes on a beat; tkeep is always left-packed so a popcount suffices.
    function automatic logic [2:0] keep_count(input logic [3:0] keep);
        return {2'b00, keep[3]} + {2'b00, keep[2]} + {2'b00, keep[1]} + {2'b00, keep[0]};
    endfunction

    // Keep the first n bytes of a big-endian word, put 0x80 right after them and
    // zero whatever follows. Bytes beyond n are never trusted, so they are masked.
    function automatic logic [WORD_W-1:0] insert_marker(input logic [WORD_W-1:0] w,
                                                        input logic [2:0]        n);
        logic [WORD_W-1:0] r;
        case (n)
            3'd0:    r = MARK_WORD;
            3'd1:    r = {w[31:24], 24'h80_0000};
            3'd2:    r = {w[31:16], 16'h8000};
            3'd3:    r = {w[31:8], 8'h80};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha256_pad.sv
// SHA-256 message padder: 32-bit byte stream in, padded 512-bit blocks out.
// Latency: block valid the cycle after the 16th or last input word is accepted.
// Backpressure: input stalls (ready low) for as long as any block is held un-taken.
module sha256_pad
    import sha256_pkg::*;
#(
    parameter int LEN_W = 61
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [WORD_W-1:0]  axis_s_tdata,
    input  logic [3:0]         axis_s_tkeep,
    input  logic               axis_s_tvalid,
    input  logic               axis_s_tlast,
    output logic               axis_s_t_ready,
    output logic [BLK_W-1:0]   axis_m_tdata,
    output logic               axis_m_tvalid,
    output logic               axis_m_tlast,
    input  logic               axis_m_t_ready
);

    pad_state_e         state_q, state_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic               tlast_q, tlast_d;
    logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [3:0]         w_idx_q, w_idx_d;
    logic               mark_pend_q, mark_pend_d;

    logic [2:0]         keep_cnt;
    logic [4:0]         mark_w;
    logic [LEN_W-1:0]   cnt_upd;
    logic [WORD_W-1:0]  last_word;
    logic               m_fire;

    // Message length in bits as it goes into the last 64 bits of the final block.
    function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] c);
        return 64'({c, 3'b000});
    endfunction

    assign axis_s_t_ready = (state_q == COLLECT);
    assign axis_m_tvalid  = (state_q != COLLECT);
    assign axis_m_tlast   = tlast_q;
    assign axis_m_tdata   = blk_q;
    assign m_fire         = axis_m_tvalid && axis_m_t_ready;

    assign keep_cnt  = keep_count(axis_s_tkeep);
    assign last_word = insert_marker(axis_s_tdata, keep_cnt);
    assign cnt_upd   = byte_cnt_q + LEN_W'(keep_cnt);
    // A full last word pushes the marker into the following word (index 16 means next block).
    assign mark_w    = (keep_cnt == 3'd4) ? ({1'b0, w_idx_q} + 5'd1) : {1'b0, w_idx_q};

    // Next-state, next-block build and counter updates.
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        tlast_d     = tlast_q;
        byte_cnt_d  = byte_cnt_q;
        w_idx_d     = w_idx_q;
        mark_pend_d = mark_pend_q;

        case (state_q)
            COLLECT: begin
                if (axis_s_tvalid) begin
                    if (!axis_s_tlast) begin
                        blk_d[BLK_W-1-WORD_W*int'(w_idx_q) -: WORD_W] = axis_s_tdata;
                        byte_cnt_d = byte_cnt_q + LEN_W'(4);
                        w_idx_d    = w_idx_q + 4'd1;
                        if (w_idx_q == 4'd15) begin
                            state_d = EMIT;
                            tlast_d = 1'b0;
                        end
                    end else begin
                        byte_cnt_d = cnt_upd;
                        // Words before the last beat are already in place; the last word,
                        // a possible marker word and zero fill are laid down here.
                        for (int k = 0; k < 16; k++) begin
                            if (5'(k) == {1'b0, w_idx_q}) begin
                                blk_d[BLK_W-1-WORD_W*k -: WORD_W] = last_word;
                            end else if (5'(k) > {1'b0, w_idx_q}) begin
                                blk_d[BLK_W-1-WORD_W*k -: WORD_W] =
                                    (5'(k) == mark_w) ? MARK_WORD : '0;
                            end
                        end
                        if (mark_w == 5'd16) begin
                            mark_pend_d = 1'b1;
                        end
                        if (mark_w <= 5'd13) begin
                            blk_d[63:0] = bit_len(cnt_upd);
                            tlast_d     = 1'b1;
                        end else begin
                            tlast_d     = 1'b0;
                        end
                        state_d = EMIT_P1;
                    end
                end
            end

            EMIT: begin
                if (m_fire) begin
                    state_d = COLLECT;
                end
            end

            EMIT_P1: begin
                if (m_fire) begin
                    if (tlast_q) begin
                        state_d     = COLLECT;
                        blk_d       = '0;
                        tlast_d     = 1'b0;
                        byte_cnt_d  = '0;
                        w_idx_d     = '0;
                        mark_pend_d = 1'b0;
                    end else begin
                        // Length did not fit: build the trailing block right away so it
                        // is presented the cycle after the handshake.
                        state_d     = EMIT_P2;
                        blk_d       = '0;
                        if (mark_pend_q) begin
                            blk_d[BLK_W-1 -: WORD_W] = MARK_WORD;
                        end
                        blk_d[63:0] = bit_len(byte_cnt_q);
                        tlast_d     = 1'b1;
                    end
                end
            end

            EMIT_P2: begin
                if (m_fire) begin
                    state_d     = COLLECT;
                    blk_d       = '0;
                    tlast_d     = 1'b0;
                    byte_cnt_d  = '0;
                    w_idx_d     = '0;
                    mark_pend_d = 1'b0;
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State, block register and counters.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= COLLECT;
            blk_q       <= '0;
            tlast_q     <= 1'b0;
            byte_cnt_q  <= '0;
            w_idx_q     <= '0;
            mark_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            tlast_q     <= tlast_d;
            byte_cnt_q  <= byte_cnt_d;
            w_idx_q     <= w_idx_d;
            mark_pend_q <= mark_pend_d;
        end
    end

endmodule

// File: tb/tb_sha256_pad.sv
// Directed bench for sha256_pad: known messages in, hand-derived padded blocks out.
// Latency: checks valid the cycle after the final accepted word.
// Backpressure: holds downstream ready low and checks the held block stays put.
module tb_sha256_pad;

    logic         clk = 1'b0;
    logic         arst_n;
    logic [31:0]  s_tdata;
    logic [3:0]   s_tkeep;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_ready;
    logic [511:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_pad #(.LEN_W(61)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .axis_s_tdata   (s_tdata),
        .axis_s_tkeep   (s_tkeep),
        .axis_s_tvalid  (s_tvalid),
        .axis_s_tlast   (s_tlast),
        .axis_s_t_ready (s_ready),
        .axis_m_tdata   (m_tdata),
        .axis_m_tvalid  (m_tvalid),
        .axis_m_tlast   (m_tlast),
        .axis_m_t_ready (m_ready)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Distinct recognisable bytes per word index.
    function automatic logic [31:0] pat(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {8'hA0 + b, 8'hB0 + b, 8'hC0 + b, 8'hD0 + b};
    endfunction

    // Block with words 0..n-1 filled from pat(), the rest zero.
    function automatic logic [511:0] pats(input int n);
        logic [511:0] e;
        e = '0;
        for (int k = 0; k < n; k++) e[511-32*k -: 32] = pat(k);
        return e;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("s_ready_timeout", {511'd0, s_ready}, 512'd1);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_msg(input int nfull, input logic [31:0] last_d, input logic [3:0] last_k);
        for (int i = 0; i < nfull; i++) send_beat(pat(i), 4'hF, 1'b0);
        send_beat(last_d, last_k, 1'b1);
    endtask

    task automatic get_block(output logic [511:0] d, output logic l);
        int n;
        n = 0;
        while (m_tvalid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("m_tvalid_timeout", {511'd0, m_tvalid}, 512'd1);
        @(negedge clk);
        d       = m_tdata;
        l       = m_tlast;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic check_block(input string tag, input logic [511:0] exp_d, input logic exp_l);
        logic [511:0] d;
        logic         l;
        get_block(d, l);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_last"}, {511'd0, l}, {511'd0, exp_l});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] e;
        logic [511:0] held_d;
        logic         held_l;
        logic [31:0]  p;

        arst_n   = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_ready  = 1'b0;

        // Reset state
        #12;
        chk("rst_mvalid", {511'd0, m_tvalid}, 512'd0);
        chk("rst_mlast",  {511'd0, m_tlast},  512'd0);
        chk("rst_mdata",  m_tdata, 512'd0);
        chk("rst_sready", {511'd0, s_ready},  512'd1);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // "abc"
        send_msg(0, 32'h6162_6300, 4'b1110);
        chk("abc_latency", {511'd0, m_tvalid}, 512'd1);
        chk("abc_sready",  {511'd0, s_ready},  512'd0);
        check_block("abc", {32'h6162_6380, 448'd0, 32'h18}, 1'b1);
        chk("abc_done",    {511'd0, m_tvalid}, 512'd0);
        chk("abc_clear",   m_tdata, 512'd0);

        // Empty message; tdata bytes must be ignored
        send_msg(0, 32'hDEAD_BEEF, 4'b0000);
        check_block("empty", {32'h8000_0000, 480'd0}, 1'b1);

        // 1 byte
        send_msg(0, 32'h41FF_FFFF, 4'b1000);
        check_block("one", {32'h4180_0000, 448'd0, 32'h8}, 1'b1);

        // 6 bytes
        send_msg(1, pat(1), 4'b1100);
        e = pats(1);
        p = pat(1);
        e[479:448] = {p[31:16], 16'h8000};
        e[63:0]    = 64'h30;
        check_block("six", e, 1'b1);

        // 55 bytes: marker at byte 55, length fits
        send_msg(13, pat(13), 4'b1110);
        e = pats(13);
        p = pat(13);
        e[511-32*13 -: 32] = {p[31:8], 8'h80};
        e[63:0]            = 64'h1B8;
        check_block("m55", e, 1'b1);

        // 56 bytes with 5 cycles of downstream backpressure
        send_msg(13, pat(13), 4'b1111);
        held_d = m_tdata;
        held_l = m_tlast;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_data",   m_tdata, held_d);
            chk("bp_last",   {511'd0, m_tlast},  {511'd0, held_l});
            chk("bp_sready", {511'd0, s_ready},  512'd0);
            chk("bp_mvalid", {511'd0, m_tvalid}, 512'd1);
        end
        e = pats(14);
        e[63:32] = 32'h8000_0000;
        check_block("m56a", e, 1'b0);
        chk("m56_nobubble", {511'd0, m_tvalid}, 512'd1);
        check_block("m56b", {448'd0, 64'h1C0}, 1'b1);

        // 60 bytes: marker lands in word 15
        send_msg(14, pat(14), 4'b1111);
        e = pats(15);
        e[31:0] = 32'h8000_0000;
        check_block("m60a", e, 1'b0);
        check_block("m60b", {448'd0, 64'h1E0}, 1'b1);

        // 64 bytes: marker spills into the next block
        send_msg(15, pat(15), 4'b1111);
        check_block("m64a", pats(16), 1'b0);
        check_block("m64b", {32'h8000_0000, 416'd0, 64'h200}, 1'b1);

        // 68 bytes: non-final full block, then a 1-word tail
        for (int i = 0; i < 16; i++) send_beat(pat(i), 4'hF, 1'b0);
        chk("m68_latency", {511'd0, m_tvalid}, 512'd1);
        chk("m68_sready",  {511'd0, s_ready},  512'd0);
        check_block("m68a", pats(16), 1'b0);
        send_beat(pat(16), 4'hF, 1'b1);
        e = '0;
        e[511:480] = pat(16);
        e[479:448] = 32'h8000_0000;
        e[63:0]    = 64'h220;
        check_block("m68b", e, 1'b1);

        // Reset in the middle of a message
        for (int i = 0; i < 5; i++) send_beat(pat(i), 4'hF, 1'b0);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_mvalid", {511'd0, m_tvalid}, 512'd0);
        chk("mid_rst_sready", {511'd0, s_ready},  512'd1);
        @(negedge clk);
        arst_n = 1'b1;

        // Reset while a block is held
        send_msg(0, 32'h6162_6300, 4'b1110);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("held_rst_mvalid", {511'd0, m_tvalid}, 512'd0);
        chk("held_rst_mdata",  m_tdata, 512'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Fresh "abc" after reset must pad from a zero length
        send_msg(0, 32'h6162_6300, 4'b1110);
        check_block("abc2", {32'h6162_6380, 448'd0, 32'h18}, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
